// File: rtl/uart_pkg.sv
// Shared UART constants: default field widths, the 16x oversample setting and
// the minimum legal divisor / oversample configuration.
package uart_pkg;

  localparam int UART_DIV_W  = 16;
  localparam int UART_FRAC_W = 4;
  localparam int UART_OSR_W  = 5;
  localparam int OSR_16X     = 15;
  localparam int MIN_DIV     = 2;
  localparam int MIN_OSR_M1  = 3;

  function automatic logic cfg_illegal(input int unsigned div, input int unsigned osr_m1);
    return (div < MIN_DIV) || (osr_m1 < MIN_OSR_M1);
  endfunction

endpackage

// File: rtl/frac_prescaler.sv
// Fractional prescaler: counts div_int (+1 when a fraction carry is pending) clocks
// per period and emits a registered 1-cycle tick when the count wraps.
module frac_prescaler #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tick_o
);

  logic [DIV_W-1:0]  pcnt_q, pcnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              tick_q, tick_d;
  logic [DIV_W:0]    period;
  logic [DIV_W:0]    pcnt_inc;
  logic [FRAC_W:0]   sum;
  logic              wrap;

  // Extra bit so div_int = all-ones plus a carry cannot overflow.
  assign period   = {1'b0, div_int_i} + (DIV_W+1)'(carry_q);
  assign pcnt_inc = {1'b0, pcnt_q} + (DIV_W+1)'(1);
  assign wrap     = (pcnt_inc == period);
  assign sum      = {1'b0, acc_q} + {1'b0, div_frac_i};

  always_comb begin
    pcnt_d  = pcnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    tick_d  = 1'b0;
    if (clr_i) begin
      pcnt_d  = '0;
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (wrap) begin
      pcnt_d           = '0;
      {carry_d, acc_d} = sum;
      tick_d           = 1'b1;
    end else begin
      pcnt_d = pcnt_inc[DIV_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// UART baud generator with fractional divisor and run-time oversample ratio:
// shadowed config, oversample phase counter, mid-bit and end-of-bit strobes.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int DIV_W  = UART_DIV_W,
  parameter int FRAC_W = UART_FRAC_W,
  parameter int OSR_W  = UART_OSR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic [OSR_W-1:0]  osr_m1,
  output logic              tick_os,
  output logic              tick_mid,
  output logic              tick_bit,
  output logic [OSR_W-1:0]  phase,
  output logic              cfg_err
);

  logic [DIV_W-1:0]  div_s_q, div_s_d;
  logic [FRAC_W-1:0] frac_s_q, frac_s_d;
  logic [OSR_W-1:0]  osr_s_q, osr_s_d;
  logic [OSR_W-1:0]  phase_q, phase_d;
  logic [OSR_W-1:0]  mid_pt;
  logic              en_q;
  logic              cfg_err_q, cfg_err_d;
  logic              tick_os_w;
  logic              illegal_s;
  logic              load;
  logic              clr;

  assign mid_pt    = osr_s_q >> 1;
  assign tick_bit  = tick_os_w && (phase_q == osr_s_q);
  assign tick_mid  = tick_os_w && (phase_q == mid_pt);
  // Config only changes at bit boundaries or while phase is being realigned.
  assign load      = !en || restart || tick_bit;
  assign illegal_s = cfg_illegal(32'(div_s_q), 32'(osr_s_q));
  // The first enabled cycle also clears, so the first tick lands div_int edges later.
  assign clr       = !en || !en_q || restart || illegal_s;

  frac_prescaler #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_presc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .div_int_i  (div_s_q),
    .div_frac_i (frac_s_q),
    .tick_o     (tick_os_w)
  );

  always_comb begin
    div_s_d  = div_s_q;
    frac_s_d = frac_s_q;
    osr_s_d  = osr_s_q;
    if (load) begin
      div_s_d  = div_int;
      frac_s_d = div_frac;
      osr_s_d  = osr_m1;
    end
    // Error stays hidden while disabled so an idle block shows all-zero outputs.
    cfg_err_d = en && cfg_illegal(32'(div_s_d), 32'(osr_s_d));
    phase_d   = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (tick_os_w) begin
      phase_d = (phase_q == osr_s_q) ? '0 : phase_q + OSR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_s_q   <= '0;
      frac_s_q  <= '0;
      osr_s_q   <= '0;
      phase_q   <= '0;
      en_q      <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      div_s_q   <= div_s_d;
      frac_s_q  <= frac_s_d;
      osr_s_q   <= osr_s_d;
      phase_q   <= phase_d;
      en_q      <= en;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick_os = tick_os_w;
  assign phase   = phase_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: table of configurations with hand-computed
// tick counts, plus sequences for restart, live reconfiguration, errors and reset.
module tb_uart_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        restart;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic [4:0]  osr_m1;
  logic        tick_os, tick_mid, tick_bit, cfg_err;
  logic [4:0]  phase;

  int total = 0;
  int bad   = 0;

  uart_baud_gen_frac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .restart  (restart),
    .div_int  (div_int),
    .div_frac (div_frac),
    .osr_m1   (osr_m1),
    .tick_os  (tick_os),
    .tick_mid (tick_mid),
    .tick_bit (tick_bit),
    .phase    (phase),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int div;
    int frac;
    int osr;
    int ncyc;
    int e_os;
    int e_mid;
    int e_bit;
    int e_first;
    int e_last;
    int e_err;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick_os !== 1'b1 && n < maxc);
  endtask

  function automatic logic [31:0] outs_all();
    return {23'd0, tick_os, tick_mid, tick_bit, cfg_err, phase};
  endfunction

  initial begin
    int n, sum;
    int c_os, c_mid, c_bit, first, last, anom;

    // div, frac, osr, cycles, #os, #mid, #bit, first, last, err
    vecs[0] = '{27, 0, uart_pkg::OSR_16X, 864, 32, 2, 2, 27, 864, 0};
    vecs[1] = '{27, 8, 15, 880, 32, 2, 2, 27, 879, 0};
    vecs[2] = '{4,  0, 3,  40,  10, 3, 2, 4,  40,  0};
    vecs[3] = '{2, 15, 3,  20,  7,  2, 1, 2,  19,  0};
    vecs[4] = '{1,  0, 15, 30,  0,  0, 0, 0,  0,   1};
    vecs[5] = '{5,  0, 2,  30,  0,  0, 0, 0,  0,   1};

    rst_n = 1'b0; en = 1'b0; restart = 1'b0;
    div_int = 16'd27; div_frac = 4'd0; osr_m1 = 5'd15;
    #12;
    chk("reset_outs", outs_all(), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_outs", outs_all(), 0);

    foreach (vecs[i]) begin
      en = 1'b0;
      div_int = 16'(vecs[i].div); div_frac = 4'(vecs[i].frac); osr_m1 = 5'(vecs[i].osr);
      step(); step();
      chk($sformatf("v%0d_err_idle", i), {31'd0, cfg_err}, 0);
      en = 1'b1;
      c_os = 0; c_mid = 0; c_bit = 0; first = 0; last = 0; anom = 0;
      for (int c = 0; c <= vecs[i].ncyc; c++) begin
        step();
        if (tick_os === 1'b1) begin
          c_os++;
          if (first == 0) first = c;
          last = c;
        end
        if (tick_mid === 1'b1) c_mid++;
        if (tick_bit === 1'b1) c_bit++;
        if ((tick_mid === 1'b1 && tick_bit === 1'b1) || int'(phase) > vecs[i].osr) anom++;
      end
      chk($sformatf("v%0d_os", i), c_os, vecs[i].e_os);
      chk($sformatf("v%0d_mid", i), c_mid, vecs[i].e_mid);
      chk($sformatf("v%0d_bit", i), c_bit, vecs[i].e_bit);
      chk($sformatf("v%0d_first", i), first, vecs[i].e_first);
      chk($sformatf("v%0d_last", i), last, vecs[i].e_last);
      chk($sformatf("v%0d_err", i), {31'd0, cfg_err}, vecs[i].e_err);
      chk($sformatf("v%0d_anom", i), anom, 0);
    end

    // Restart at phase 9, then restart coincident with a tick.
    en = 1'b0; div_int = 16'd27; div_frac = 4'd0; osr_m1 = 5'd15;
    step(); step();
    en = 1'b1;
    step();
    sum = 0;
    repeat (9) begin wait_tick(60, n); sum += n; end
    chk("pre_restart_time", sum, 243);
    step();
    chk("pre_restart_phase", phase, 9);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_clear", {26'd0, tick_os, phase}, 0);
    wait_tick(100, n);
    chk("restart_first", n, 27);
    chk("restart_phase", phase, 0);
    repeat (26) step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_prio", {31'd0, tick_os}, 0);
    wait_tick(100, n);
    chk("restart_prio_next", n, 27);

    // Live divisor change at phase 4 takes effect only after the bit ends.
    repeat (4) wait_tick(60, n);
    chk("chg_phase", phase, 4);
    div_int = 16'd13;
    sum = 0;
    repeat (11) begin wait_tick(60, n); sum += n; end
    chk("chg_old_period", sum, 297);
    chk("chg_tick_bit", {31'd0, tick_bit}, 1);
    wait_tick(60, n);
    chk("chg_new_period1", n, 13);
    wait_tick(60, n);
    chk("chg_new_period2", n, 13);

    // Illegal divisor, then recovery by restart.
    en = 1'b0; div_int = 16'd1;
    step(); step();
    en = 1'b1;
    repeat (3) step();
    chk("err_set", {31'd0, cfg_err}, 1);
    wait_tick(60, n);
    chk("err_no_tick", {n[30:0], tick_os}, {31'd60, 1'b0});
    div_int = 16'd4; restart = 1'b1;
    step();
    restart = 1'b0;
    chk("err_clear", {31'd0, cfg_err}, 0);
    wait_tick(60, n);
    chk("rec_first", n, 4);
    wait_tick(60, n);
    chk("rec_period", n, 4);

    // en dropped on the tick edge, re-enabled, then async reset mid-bit.
    div_int = 16'd27; restart = 1'b1;
    step();
    restart = 1'b0;
    wait_tick(100, n);
    chk("reload_first", n, 27);
    repeat (26) step();
    en = 1'b0;
    step();
    chk("en_drop", {26'd0, tick_os, phase}, 0);
    repeat (3) step();
    en = 1'b1;
    step();
    wait_tick(100, n);
    chk("en_rise_first", n, 27);
    repeat (10) step();
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", outs_all(), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_idle", outs_all(), 0);
    en = 1'b1;
    step();
    wait_tick(100, n);
    chk("post_rst_first", n, 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
